mux6_rr_arbiter: RTL and testbench
==================================

MUX6_RR_ARBITER -- requirements
Module: mux6_rr_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 16: maximum cycles one owner may hold a grant when the timeout is compiled in; legal range 2..255.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST_N  input  1  reset, asynchronous, active-low.
REQ-004 REQ  input  6  request per source; bit i corresponds to mux data input Di.
REQ-005 DONE  input  1  current owner releases the mux (pulse, sampled only while VALID=1).
REQ-006 GNT  output  6  one-hot grant; registered.
REQ-007 SEL  output  3  mux select (0..5) for the shared 6-to-1 mux; registered.
REQ-008 VALID  output  1  high while a grant is active; registered.
REQ-009 TIMEOUT  output  1  one-cycle pulse when a grant is forcibly revoked; registered.

Function
REQ-010 The arbiter SHALL be a two-state FSM: IDLE, OWNED.
REQ-011 IDLE: GNT=0, VALID=0, SEL holds the last granted index.
REQ-012 IDLE -> OWNED on the first edge where REQ != 0; that same edge loads GNT, SEL and VALID=1 (1-cycle request-to-grant latency).
REQ-013 Winner selection is round-robin: search starts at index (LAST+1) mod 6 and proceeds upward with wrap 5->0; LAST = index of the most recent grant.
REQ-014 With LAST=5, the search order is 0,1,2,3,4,5.
REQ-015 OWNED -> IDLE on the first edge where any of the following holds: DONE=1, REQ[SEL]=0, or a timeout (REQ-019).
REQ-016 On any OWNED->IDLE edge: GNT=0, VALID=0, LAST=SEL, SEL unchanged.
REQ-017 Exactly one IDLE cycle (turnaround) separates consecutive grants; back-to-back grants are forbidden.
REQ-018 DONE and REQ changes for non-owner bits SHALL NOT affect OWNED; DONE is ignored in IDLE.
REQ-019 Hold counter: cleared on IDLE->OWNED, increments each OWNED cycle, saturates at MAX_HOLD.
REQ-020 SEL SHALL always be in 0..5; GNT SHALL equal one-hot(SEL) when VALID=1 and 0 otherwise.
REQ-021 Simultaneous DONE and timeout on one edge: treat as a normal release, TIMEOUT=0.
REQ-022 A requester that keeps REQ high after release is not eligible until the rotation reaches it again, which makes the arbitration fair and starvation-free.

Reset
REQ-023 RST_N=0 SHALL immediately force state IDLE, GNT=0, SEL=0, VALID=0, TIMEOUT=0, hold counter=0, LAST=5.
REQ-024 Reset during OWNED SHALL drop the grant asynchronously, with no TIMEOUT pulse.
REQ-025 After RST_N deasserts, the first grant is evaluated on the next rising edge.

Configuration
REQ-026 Macro MUX6_ARB_TIMEOUT_EN defined: while OWNED, if the hold counter equals MAX_HOLD-1 and no other release applies, the next edge releases the grant and pulses TIMEOUT for one cycle.
REQ-027 MUX6_ARB_TIMEOUT_EN undefined: no hold counter is built, TIMEOUT is tied to 0, and a grant is held until DONE or the owner's REQ drops.

Verification
REQ-028 Reset then REQ=6'b000100 -> next edge GNT=6'b000100, SEL=2, VALID=1; DONE pulse -> next edge VALID=0, SEL=2.
REQ-029 REQ=6'b111111 held, DONE pulsed each grant -> grant order 0,1,2,3,4,5,0, with one idle cycle between grants.
REQ-030 LAST=3, REQ=6'b001001 -> grant to 0 (wrap); owner 0 drops REQ without DONE -> release on the next edge.
REQ-031 MUX6_ARB_TIMEOUT_EN, MAX_HOLD=4, REQ=6'b000010 held, no DONE -> VALID high 4 cycles, TIMEOUT pulse, one IDLE cycle, regrant to 1; without the macro -> VALID stays high indefinitely.
REQ-032 RST_N low mid-OWNED (SEL=4) -> GNT=0, SEL=0, VALID=0 immediately, before the next clock edge.
REQ-033 DONE asserted in IDLE with REQ=0 -> no state change; DONE and timeout on the same edge -> release with TIMEOUT=0.

Source files
------------

// File: rtl/mux6_rr_arbiter.sv
// rtl/mux6_rr_arbiter.sv - round-robin arbiter driving the select of a shared 6-to-1 mux
// Optional grant timeout: define MUX6_ARB_TIMEOUT_EN.
module mux6_rr_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] req,
  input  logic       done,
  output logic [5:0] gnt,
  output logic [2:0] sel,
  output logic       valid,
  output logic       timeout
);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t     state;
  logic [2:0] last;
  logic [2:0] pick;
  logic       release_req;
  logic       hold_exp;

  // Search starts just after the last owner, wrapping 5 -> 0.
  function automatic logic [2:0] rr_pick(input logic [5:0] r, input logic [2:0] l);
    logic [2:0] idx;
    logic [2:0] win;
    logic       found;
    idx   = l;
    win   = l;
    found = 1'b0;
    for (int k = 0; k < 6; k++) begin
      idx = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
      if (!found && r[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  assign pick        = rr_pick(req, last);
  // gnt is one-hot(sel) while owned, so this masks the owner's request bit.
  assign release_req = done || ((req & gnt) == 6'd0);

`ifdef MUX6_ARB_TIMEOUT_EN
  logic [7:0] hold_cnt;
  assign hold_exp = (hold_cnt == 8'(MAX_HOLD - 1));
`else
  assign hold_exp = 1'b0;
  assign timeout  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= 6'd0;
      sel   <= 3'd0;
      valid <= 1'b0;
      last  <= 3'd5;
`ifdef MUX6_ARB_TIMEOUT_EN
      hold_cnt <= 8'd0;
      timeout  <= 1'b0;
`endif
    end else begin
`ifdef MUX6_ARB_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (|req) begin
            state <= OWNED;
            sel   <= pick;
            gnt   <= 6'd1 << pick;
            valid <= 1'b1;
`ifdef MUX6_ARB_TIMEOUT_EN
            hold_cnt <= 8'd0;
`endif
          end
        end
        OWNED: begin
          if (release_req || hold_exp) begin
            state <= IDLE;
            gnt   <= 6'd0;
            valid <= 1'b0;
            last  <= sel;
`ifdef MUX6_ARB_TIMEOUT_EN
            // A normal release on the same edge wins over the timeout.
            timeout <= !release_req;
`endif
          end else begin
`ifdef MUX6_ARB_TIMEOUT_EN
            if (hold_cnt != 8'(MAX_HOLD))
              hold_cnt <= hold_cnt + 8'd1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux6_rr_arbiter.sv
// tb/tb_mux6_rr_arbiter.sv - randomized and directed checks of mux6_rr_arbiter against a reference model
module tb_mux6_rr_arbiter;

  localparam int MAX_HOLD = 4;

  logic       clk;
  logic       rst_n;
  logic [5:0] req;
  logic       done;
  logic [5:0] gnt;
  logic [2:0] sel;
  logic       valid;
  logic       timeout;

  int n_chk;
  int n_bad;

  // reference model: owner index or -1 when idle
  int m_owner;
  int m_last;
  int m_sel;
  int m_hold;
  int m_tout;

  mux6_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .sel     (sel),
    .valid   (valid),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = 5;
    m_sel   = 0;
    m_hold  = 0;
    m_tout  = 0;
  endtask

  task automatic model_edge(input logic [5:0] r, input logic d);
    int rel;
    int to;
    m_tout = 0;
    if (m_owner < 0) begin
      if (r != 6'd0) begin
        for (int k = 1; k <= 6; k++) begin
          if (m_owner < 0 && r[(m_last + k) % 6]) m_owner = (m_last + k) % 6;
        end
        m_sel  = m_owner;
        m_hold = 0;
      end
    end else begin
      rel = (d || !r[m_owner]) ? 1 : 0;
      to  = 0;
`ifdef MUX6_ARB_TIMEOUT_EN
      if (!rel && m_hold == MAX_HOLD - 1) to = 1;
`endif
      if (rel || to) begin
        m_last  = m_owner;
        m_owner = -1;
        m_tout  = to;
      end else if (m_hold < MAX_HOLD) begin
        m_hold++;
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [5:0] eg;
    eg = (m_owner >= 0) ? (6'd1 << m_owner) : 6'd0;
    chk({tag, ".gnt"}, 8'(gnt), 8'(eg));
    chk({tag, ".sel"}, 8'(sel), 8'(m_sel));
    chk({tag, ".valid"}, 8'(valid), (m_owner >= 0) ? 8'd1 : 8'd0);
    chk({tag, ".timeout"}, 8'(timeout), 8'(m_tout));
  endtask

  task automatic step(input logic [5:0] r, input logic d, input string tag);
    req  = r;
    done = d;
    @(posedge clk);
    model_edge(r, d);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    req   = 6'd0;
    done  = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    req   = 6'd0;
    done  = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #2;
    check_all("por");
    do_reset();

    // single requester, then DONE release keeps SEL
    step(6'b000100, 1'b0, "r028_grant");
    chk("r028_sel", 8'(sel), 8'd2);
    step(6'b000100, 1'b1, "r028_done");
    chk("r028_rel_valid", 8'(valid), 8'd0);
    chk("r028_rel_sel", 8'(sel), 8'd2);

    // all requesting: rotation 0..5,0 with one idle cycle between grants
    do_reset();
    for (int g = 0; g < 7; g++) begin
      step(6'b111111, 1'b0, "r029_grant");
      chk("r029_order", 8'(sel), 8'(g % 6));
      step(6'b111111, 1'b1, "r029_rel");
      chk("r029_idle", 8'(valid), 8'd0);
    end

    // wrap from LAST=3 to index 0; owner drops REQ
    do_reset();
    step(6'b001000, 1'b0, "r030_g3");
    step(6'b001000, 1'b1, "r030_r3");
    step(6'b001001, 1'b0, "r030_g0");
    chk("r030_wrap", 8'(sel), 8'd0);
    step(6'b001000, 1'b0, "r030_drop");
    chk("r030_drop_valid", 8'(valid), 8'd0);

    // held request with no DONE
    do_reset();
    begin
      int vcnt;
      int tcnt;
      vcnt = 0;
      tcnt = 0;
      for (int c = 0; c < 12; c++) begin
        step(6'b000010, 1'b0, "r031");
        vcnt += valid ? 1 : 0;
        tcnt += timeout ? 1 : 0;
      end
`ifdef MUX6_ARB_TIMEOUT_EN
      chk("r031_timeouts", 8'(tcnt), 8'd2);
`else
      chk("r031_held", 8'(vcnt), 8'd12);
      chk("r031_no_timeout", 8'(tcnt), 8'd0);
`endif
    end

    // asynchronous reset while owned by 4
    do_reset();
    step(6'b010000, 1'b0, "r032_grant");
    chk("r032_sel4", 8'(sel), 8'd4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("r032_gnt", 8'(gnt), 8'd0);
    chk("r032_sel", 8'(sel), 8'd0);
    chk("r032_valid", 8'(valid), 8'd0);
    chk("r032_timeout", 8'(timeout), 8'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // DONE in IDLE is ignored
    step(6'b000000, 1'b1, "r033_idle");
    step(6'b000000, 1'b1, "r033_idle2");
`ifdef MUX6_ARB_TIMEOUT_EN
    step(6'b000010, 1'b0, "r033_g");
    for (int c = 0; c < MAX_HOLD - 1; c++) step(6'b000010, 1'b0, "r033_hold");
    step(6'b000010, 1'b1, "r033_both");
    chk("r033_both_to", 8'(timeout), 8'd0);
`endif

    // randomized traffic with occasional asynchronous reset
    do_reset();
    begin
      logic [5:0] r;
      r = 6'd0;
      for (int c = 0; c < 600; c++) begin
        if ($urandom_range(0, 99) == 0) begin
          do_reset();
        end else begin
          if ($urandom_range(0, 3) == 0) r = 6'($urandom);
          step(r, ($urandom_range(0, 4) == 0), "rand");
        end
      end
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
